// File: rtl/fp_div_share_pkg.sv
// Shared types and sizing helpers for the fixed-point divider share arbiter.
package fp_div_share_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    function automatic int div_latency(input int width, input int frac_width);
        return width + frac_width + 1;
    endfunction

    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

    localparam int DIV_LATENCY = div_latency(32, 8);

endpackage

// File: rtl/fp_div_share_arbiter_if.sv
// Request/response bundle between the requesters and the divider share arbiter.
interface fp_div_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_left;
    logic [NUM_REQ*WIDTH-1:0] req_right;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [WIDTH-1:0]         resp_quotient;
    logic [WIDTH-1:0]         resp_remainder;
    logic                     resp_dbz;
    logic                     resp_timeout;

    modport master (
        output req_valid, req_left, req_right, resp_ready,
        input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_dbz, resp_timeout
    );

    modport slave (
        input  req_valid, req_left, req_right, resp_ready,
        output req_ready, resp_valid, resp_quotient, resp_remainder, resp_dbz, resp_timeout
    );
endinterface

// File: rtl/fp_div_share_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end
endmodule

// File: rtl/std_fp_div_pipe_32_24_8.sv
// Iterative restoring fixed-point divider: (left<<FRAC_WIDTH)/right, level-held go, one-cycle done.
module std_fp_div_pipe_32_24_8 #(
    parameter int WIDTH      = 32,
    parameter int FRAC_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done
);
    localparam int IT = WIDTH + FRAC_WIDTH;
    localparam int CW = $clog2(IT);

    logic             running;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, divisor, rem_n;
    logic [IT-1:0]    dq, dq_n;
    logic [WIDTH:0]   trial;
    logic             fits;

    always_comb begin
        trial = {rem, dq[IT-1]};
        fits  = trial >= {1'b0, divisor};
        rem_n = fits ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
        dq_n  = {dq[IT-2:0], fits};
    end

    // Outputs only change on completion, so the result survives go dropping afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            running       <= 1'b0;
            cnt           <= '0;
            rem           <= '0;
            divisor       <= '0;
            dq            <= '0;
            out_quotient  <= '0;
            out_remainder <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!running) begin
                if (go) begin
                    if (left == '0) begin
                        out_quotient  <= '0;
                        out_remainder <= '0;
                        done          <= 1'b1;
                    end else begin
                        dq      <= {left, {FRAC_WIDTH{1'b0}}};
                        rem     <= '0;
                        divisor <= right;
                        cnt     <= '0;
                        running <= 1'b1;
                    end
                end
            end else if (!go) begin
                running <= 1'b0;
            end else begin
                rem <= rem_n;
                dq  <= dq_n;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(IT - 1)) begin
                    running       <= 1'b0;
                    done          <= 1'b1;
                    out_quotient  <= dq_n[WIDTH-1:0];
                    out_remainder <= rem_n;
                end
            end
        end
    end
endmodule

// File: rtl/fp_div_share_arbiter.sv
// Round-robin share of one fixed-point divider among NUM_REQ requesters, one op outstanding.
module fp_div_share_arbiter
    import fp_div_share_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 32,
    parameter int FRAC_WIDTH = 8,
    parameter int TIMEOUT    = 63
) (
    input  logic clk,
    input  logic reset,
    fp_div_share_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = cnt_width(TIMEOUT);

    state_t             state, nstate;
    logic [IW-1:0]      ptr, owner, g_idx;
    logic [NUM_REQ-1:0] grant;
    logic               g_any, take, timeout_hit, div_go, div_done;
    logic [WIDTH-1:0]   left_q, right_q, div_q, div_r, quo_q, rem_q, sel_left, sel_right;
    logic               dbz_q, to_q;
    logic [CW-1:0]      busy_cnt;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (g_idx),
        .any   (g_any)
    );

    std_fp_div_pipe_32_24_8 #(.WIDTH(WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_div (
        .clk           (clk),
        .reset         (reset),
        .go            (div_go),
        .left          (left_q),
        .right         (right_q),
        .out_quotient  (div_q),
        .out_remainder (div_r),
        .done          (div_done)
    );

    assign sel_left    = bus.req_left[int'(g_idx) * WIDTH +: WIDTH];
    assign sel_right   = bus.req_right[int'(g_idx) * WIDTH +: WIDTH];
    assign timeout_hit = busy_cnt >= CW'(TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    // Go is released in the done cycle so the divider neither restarts nor clears its result.
    always_comb begin
        nstate         = state;
        div_go         = 1'b0;
        take           = 1'b0;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        case (state)
            IDLE: begin
                if (!reset && g_any) begin
                    bus.req_ready = grant;
                    take          = 1'b1;
                    nstate        = BUSY;
                end
            end
            BUSY: begin
                div_go = !div_done && !timeout_hit;
                if (div_done || timeout_hit) nstate = RESP;
            end
            RESP: begin
                bus.resp_valid[owner] = 1'b1;
                if (bus.resp_ready[owner]) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            owner    <= '0;
            left_q   <= '0;
            right_q  <= '0;
            dbz_q    <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            to_q     <= 1'b0;
            busy_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        left_q   <= sel_left;
                        right_q  <= sel_right;
                        dbz_q    <= (sel_right == '0);
                        owner    <= g_idx;
                        ptr      <= (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
                        busy_cnt <= '0;
                    end
                end
                BUSY: begin
                    busy_cnt <= busy_cnt + 1'b1;
                    if (div_done) begin
                        quo_q <= div_q;
                        rem_q <= div_r;
                        to_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        quo_q <= '0;
                        rem_q <= '0;
                        to_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_quotient  = quo_q;
    assign bus.resp_remainder = rem_q;
    assign bus.resp_dbz       = dbz_q;
    assign bus.resp_timeout   = to_q;
endmodule

// File: tb/tb_fp_div_share_arbiter.sv
// Directed bench for fp_div_share_arbiter: latency, results, flags, round-robin order, reset and timeout.
module tb_fp_div_share_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    fp_div_share_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) bus ();

    fp_div_share_arbiter #(.NUM_REQ(4), .WIDTH(32), .FRAC_WIDTH(8), .TIMEOUT(63)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Present a request at a negedge, wait for its grant, and return at the negedge after acceptance.
    task automatic issue(input int r, input logic [31:0] l, input logic [31:0] rt, output bit granted);
        int n;
        bus.req_left[r*32 +: 32]  = l;
        bus.req_right[r*32 +: 32] = rt;
        bus.req_valid[r]          = 1'b1;
        n = 0;
        #1;
        while (!bus.req_ready[r] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        granted = bus.req_ready[r];
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic wait_resp(input int r, output int cycles);
        cycles = 0;
        while (!bus.resp_valid[r] && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic consume(input int r);
        bus.resp_ready[r] = 1'b1;
        @(negedge clk);
        bus.resp_ready[r] = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.req_ready !== 4'b0) $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); else passed++;
        total++; if (bus.resp_valid !== 4'b0) $display("FAIL reset_resp_valid got %b want 0000", bus.resp_valid); else passed++;
        total++; if (bus.resp_quotient !== 32'h0) $display("FAIL reset_quotient got %h want 0", bus.resp_quotient); else passed++;
        total++; if ({bus.resp_dbz, bus.resp_timeout} !== 2'b00) $display("FAIL reset_flags got %b want 00", {bus.resp_dbz, bus.resp_timeout}); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit g;
        int c;
        issue(0, 32'h600, 32'h200, g);
        total++; if (g !== 1'b1) $display("FAIL basic_grant got %b want 1", g); else passed++;
        wait_resp(0, c);
        total++; if (c != 42) $display("FAIL basic_latency got %0d want 42", c); else passed++;
        total++; if (bus.resp_quotient !== 32'h300) $display("FAIL basic_quotient got %h want 00000300", bus.resp_quotient); else passed++;
        total++; if (bus.resp_remainder !== 32'h0) $display("FAIL basic_remainder got %h want 0", bus.resp_remainder); else passed++;
        total++; if ({bus.resp_dbz, bus.resp_timeout} !== 2'b00) $display("FAIL basic_flags got %b want 00", {bus.resp_dbz, bus.resp_timeout}); else passed++;
        consume(0);
        total++; if (bus.resp_valid !== 4'b0) $display("FAIL basic_resp_drop got %b want 0000", bus.resp_valid); else passed++;
    endtask

    task automatic test_zero_dividend;
        bit g;
        int c;
        issue(1, 32'h0, 32'h100, g);
        wait_resp(1, c);
        total++; if (c != 2) $display("FAIL zero_latency got %0d want 2", c); else passed++;
        repeat (4) @(negedge clk);
        total++; if ({bus.resp_valid, bus.resp_quotient} !== {4'b0010, 32'h0}) $display("FAIL zero_held got %b/%h want 0010/0", bus.resp_valid, bus.resp_quotient); else passed++;
        consume(1);
    endtask

    task automatic test_dbz;
        bit g;
        int c;
        issue(2, 32'h100, 32'h0, g);
        wait_resp(2, c);
        total++; if (bus.resp_quotient !== 32'hFFFF_FFFF) $display("FAIL dbz_quotient got %h want ffffffff", bus.resp_quotient); else passed++;
        total++; if ({bus.resp_dbz, bus.resp_timeout} !== 2'b10) $display("FAIL dbz_flags got %b want 10", {bus.resp_dbz, bus.resp_timeout}); else passed++;
        consume(2);
    endtask

    task automatic test_round_robin;
        bit g;
        int c;
        issue(3, 32'h100, 32'h100, g);
        wait_resp(3, c);
        total++; if (bus.resp_quotient !== 32'h100) $display("FAIL rr_prep_quotient got %h want 00000100", bus.resp_quotient); else passed++;
        consume(3);
        bus.req_left[0*32 +: 32] = 32'hA00; bus.req_right[0*32 +: 32] = 32'h200;
        bus.req_left[2*32 +: 32] = 32'h300; bus.req_right[2*32 +: 32] = 32'h100;
        bus.req_valid = 4'b0101;
        #1;
        total++; if (bus.req_ready !== 4'b0001) $display("FAIL rr_first_grant got %b want 0001", bus.req_ready); else passed++;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0000) $display("FAIL rr_busy_ready got %b want 0000", bus.req_ready); else passed++;
        wait_resp(0, c);
        total++; if (bus.resp_quotient !== 32'h500) $display("FAIL rr_q0 got %h want 00000500", bus.resp_quotient); else passed++;
        consume(0);
        total++; if (bus.req_ready !== 4'b0100) $display("FAIL rr_second_grant got %b want 0100", bus.req_ready); else passed++;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        wait_resp(2, c);
        total++; if (bus.resp_quotient !== 32'h300) $display("FAIL rr_q2 got %h want 00000300", bus.resp_quotient); else passed++;
        consume(2);
        // Pointer must now sit at 3: requester 3 beats requester 0.
        bus.req_left[0*32 +: 32] = 32'h0; bus.req_left[3*32 +: 32] = 32'h0;
        bus.req_valid = 4'b1001;
        #1;
        total++; if (bus.req_ready !== 4'b1000) $display("FAIL rr_ptr3_grant got %b want 1000", bus.req_ready); else passed++;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 4'b0;
        wait_resp(3, c);
        consume(3);
    endtask

    task automatic test_resp_hold;
        bit g;
        int c;
        issue(1, 32'h400, 32'h100, g);
        wait_resp(1, c);
        bus.req_left[3*32 +: 32] = 32'h200; bus.req_right[3*32 +: 32] = 32'h100;
        bus.req_valid[3] = 1'b1;
        bus.resp_ready   = 4'b0101;
        #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({bus.resp_valid, bus.req_ready, bus.resp_quotient} !== {4'b0010, 4'b0000, 32'h400})
                $display("FAIL hold_cycle%0d got %b/%b/%h want 0010/0000/00000400", i, bus.resp_valid, bus.req_ready, bus.resp_quotient);
            else passed++;
            @(negedge clk);
            #1;
        end
        bus.resp_ready = 4'b0;
        consume(1);
        total++; if (bus.req_ready !== 4'b1000) $display("FAIL hold_next_grant got %b want 1000", bus.req_ready); else passed++;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        wait_resp(3, c);
        total++; if ({c, bus.resp_quotient} !== {32'd42, 32'h200}) $display("FAIL hold_q3 got %0d/%h want 42/00000200", c, bus.resp_quotient); else passed++;
        consume(3);
    endtask

    task automatic test_reset_mid;
        bit g;
        bit seen;
        int c;
        issue(0, 32'h600, 32'h200, g);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_quotient, bus.resp_dbz, bus.resp_timeout} !== '0)
            $display("FAIL midreset_outputs got %b/%b/%h want all zero", bus.req_ready, bus.resp_valid, bus.resp_quotient);
        else passed++;
        reset = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (bus.resp_valid !== 4'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL midreset_no_resp got %b want 0", seen); else passed++;
        issue(0, 32'h600, 32'h200, g);
        wait_resp(0, c);
        total++; if ({c, bus.resp_quotient} !== {32'd42, 32'h300}) $display("FAIL midreset_rerun got %0d/%h want 42/00000300", c, bus.resp_quotient); else passed++;
        consume(0);
    endtask

    task automatic test_timeout;
        bit g;
        int c;
        force u_dut.div_done = 1'b0;
        issue(2, 32'h600, 32'h200, g);
        wait_resp(2, c);
        total++; if (c != 64) $display("FAIL timeout_latency got %0d want 64", c); else passed++;
        total++; if ({bus.resp_timeout, bus.resp_dbz} !== 2'b10) $display("FAIL timeout_flags got %b want 10", {bus.resp_timeout, bus.resp_dbz}); else passed++;
        total++; if ({bus.resp_quotient, bus.resp_remainder} !== 64'h0) $display("FAIL timeout_data got %h/%h want 0/0", bus.resp_quotient, bus.resp_remainder); else passed++;
        release u_dut.div_done;
        consume(2);
        issue(2, 32'h600, 32'h200, g);
        wait_resp(2, c);
        total++; if ({c, bus.resp_quotient, bus.resp_timeout} !== {32'd42, 32'h300, 1'b0}) $display("FAIL timeout_recover got %0d/%h/%b want 42/00000300/0", c, bus.resp_quotient, bus.resp_timeout); else passed++;
        consume(2);
    endtask

    initial begin
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_left   = '0;
        bus.req_right  = '0;
        bus.resp_ready = '0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_zero_dividend;
        test_dbz;
        test_round_robin;
        test_resp_hold;
        test_reset_mid;
        test_timeout;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
